// File: rtl/dcache_store_port.sv
// L1 D$ write-side responder: takes committed stores from the store buffer,
// probes the tag array, writes the data array on a hit (write-through,
// no-write-allocate) and always forwards a byte-masked word write to memory.

package dcache_store_port_pkg;
  typedef enum logic [1:0] {
    LSU_SB = 2'd0,
    LSU_SH = 2'd1,
    LSU_SW = 2'd2,
    LSU_SD = 2'd3
  } lsu_op_e;
endpackage

// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a store; tag read issued in the accept cycle
// LOOKUP   | tag compare; data array written on a hit
// MEM_REQ  | bus write valid, payload held until mem_req_ready_i
// MEM_RESP | waiting for the bus write response
module dcache_store_port
  import dcache_store_port_pkg::*;
#(
  parameter int unsigned PLEN       = 32,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_SETS   = 64,
  parameter int unsigned LINE_BYTES = 32,
  localparam int unsigned IDX_W = $clog2(NUM_SETS),
  localparam int unsigned OFF_W = $clog2(LINE_BYTES),
  localparam int unsigned TAG_W = PLEN - IDX_W - OFF_W,
  localparam int unsigned BE_W  = XLEN / 8,
  localparam int unsigned BO_W  = $clog2(BE_W),
  localparam int unsigned WO_W  = OFF_W - BO_W,
  localparam int unsigned WA_W  = PLEN - BO_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [PLEN-1:0]  req_addr_i,
  input  logic [XLEN-1:0]  req_data_i,
  input  lsu_op_e          req_op_i,
  output logic             tag_rd_en_o,
  output logic [IDX_W-1:0] tag_rd_idx_o,
  input  logic [TAG_W-1:0] tag_rd_tag_i,
  input  logic             tag_rd_vld_i,
  output logic             data_wr_en_o,
  output logic [IDX_W-1:0] data_wr_idx_o,
  output logic [WO_W-1:0]  data_wr_off_o,
  output logic [XLEN-1:0]  data_wr_data_o,
  output logic [BE_W-1:0]  data_wr_be_o,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [PLEN-1:0]  mem_req_addr_o,
  output logic [XLEN-1:0]  mem_req_data_o,
  output logic [BE_W-1:0]  mem_req_be_o,
  input  logic             mem_resp_valid_i,
  input  logic             mem_resp_err_i,
  output logic             busy_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOOKUP   = 2'd1,
    S_MEM_REQ  = 2'd2,
    S_MEM_RESP = 2'd3
  } state_e;

  state_e           state;
  logic [WA_W-1:0]  waddr_q;    // word address; byte lane is folded into be/data
  logic [XLEN-1:0]  data_q;
  logic [BE_W-1:0]  be_q;
  logic             ready_q;
  logic             busy_q;
  logic             mem_valid_q;
  logic             err_q;

  logic [BE_W-1:0]  be_base;
  logic             legal;
  logic [BO_W-1:0]  lane;
  logic [BE_W-1:0]  be_shift;
  logic [XLEN-1:0]  data_shift;
  logic             fire_ok;
  logic             hit;

  // Decode the op into a base byte mask and check size/alignment legality.
  always_comb begin
    be_base = '0;
    legal   = 1'b0;
    case (req_op_i)
      LSU_SB: begin
        be_base = BE_W'(1);
        legal   = 1'b1;
      end
      LSU_SH: begin
        be_base = BE_W'(3);
        legal   = ~req_addr_i[0];
      end
      LSU_SW: begin
        be_base = BE_W'(4'hF);
        legal   = (req_addr_i[1:0] == 2'b00);
      end
      LSU_SD: begin
        be_base = BE_W'(8'hFF);
        legal   = (XLEN == 64) && (req_addr_i[2:0] == 3'b000);
      end
      default: ;
    endcase
  end

  assign lane       = req_addr_i[BO_W-1:0];
  assign be_shift   = be_base << lane;
  assign data_shift = req_data_i << {lane, 3'b000};

  // The tag read goes out in the accept cycle so the result lands in LOOKUP.
  assign fire_ok      = req_valid_i && (state == S_IDLE) && legal;
  assign tag_rd_en_o  = fire_ok;
  assign tag_rd_idx_o = fire_ok ? req_addr_i[OFF_W +: IDX_W] : '0;

  assign hit = (state == S_LOOKUP) && tag_rd_vld_i &&
               (tag_rd_tag_i == waddr_q[WA_W-1 -: TAG_W]);

  assign data_wr_en_o   = hit;
  assign data_wr_idx_o  = waddr_q[WO_W +: IDX_W];
  assign data_wr_off_o  = waddr_q[WO_W-1:0];
  assign data_wr_data_o = data_q;
  assign data_wr_be_o   = be_q;

  assign mem_req_valid_o = mem_valid_q;
  assign mem_req_addr_o  = {waddr_q, {BO_W{1'b0}}};
  assign mem_req_data_o  = data_q;
  assign mem_req_be_o    = be_q;

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  // Bus errors flag in the response cycle; request errors one cycle after accept.
  assign err_o = err_q ||
                 ((state == S_MEM_RESP) && mem_resp_valid_i && mem_resp_err_i);

  // Sequencer: one store in flight at a time, outputs registered alongside state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      waddr_q     <= '0;
      data_q      <= '0;
      be_q        <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            if (legal) begin
              waddr_q <= req_addr_i[PLEN-1:BO_W];
              data_q  <= data_shift;
              be_q    <= be_shift;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
              state   <= S_LOOKUP;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LOOKUP: begin
          mem_valid_q <= 1'b1;
          state       <= S_MEM_REQ;
        end
        S_MEM_REQ: begin
          if (mem_req_ready_i) begin
            mem_valid_q <= 1'b0;
            state       <= S_MEM_RESP;
          end
        end
        S_MEM_RESP: begin
          if (mem_resp_valid_i) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_store_port.sv
// Directed bench for dcache_store_port: a table of stores with hand-computed
// lane/mask/address results, plus stall, bus-error and mid-flight reset sequences.

module tb_dcache_store_port;
  import dcache_store_port_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  lsu_op_e     req_op_i;
  logic        tag_rd_en_o;
  logic [5:0]  tag_rd_idx_o;
  logic [20:0] tag_rd_tag_i;
  logic        tag_rd_vld_i;
  logic        data_wr_en_o;
  logic [5:0]  data_wr_idx_o;
  logic [2:0]  data_wr_off_o;
  logic [31:0] data_wr_data_o;
  logic [3:0]  data_wr_be_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic [31:0] mem_req_data_o;
  logic [3:0]  mem_req_be_o;
  logic        mem_resp_valid_i;
  logic        mem_resp_err_i;
  logic        busy_o;
  logic        err_o;

  int n_cmp = 0;
  int n_err = 0;

  dcache_store_port dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_data_i      (req_data_i),
    .req_op_i        (req_op_i),
    .tag_rd_en_o     (tag_rd_en_o),
    .tag_rd_idx_o    (tag_rd_idx_o),
    .tag_rd_tag_i    (tag_rd_tag_i),
    .tag_rd_vld_i    (tag_rd_vld_i),
    .data_wr_en_o    (data_wr_en_o),
    .data_wr_idx_o   (data_wr_idx_o),
    .data_wr_off_o   (data_wr_off_o),
    .data_wr_data_o  (data_wr_data_o),
    .data_wr_be_o    (data_wr_be_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_data_o  (mem_req_data_o),
    .mem_req_be_o    (mem_req_be_o),
    .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_err_i  (mem_resp_err_i),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    lsu_op_e     op;
    logic [31:0] addr;
    logic [31:0] data;
    bit          tag_match;
    bit          tag_vld;
    bit          exp_legal;
    bit          exp_wr;
    logic [5:0]  exp_idx;
    logic [2:0]  exp_off;
    logic [3:0]  exp_be;
    logic [31:0] exp_data;
    logic [31:0] exp_maddr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one store end to end; stall = extra cycles mem_req_ready_i stays low.
  task automatic run_store(input int id, input vec_t v, input int stall, input bit rerr);
    string p;
    p = $sformatf("v%0d ", id);
    tag_rd_tag_i = v.tag_match ? v.addr[31:11] : (v.addr[31:11] ^ 21'h1);
    tag_rd_vld_i = v.tag_vld;
    req_valid_i  = 1'b1;
    req_addr_i   = v.addr;
    req_data_i   = v.data;
    req_op_i     = v.op;
    #1;
    chk({p, "ready_idle"}, 32'(req_ready_o), 32'd1);
    chk({p, "tag_rd_en"}, 32'(tag_rd_en_o), 32'(v.exp_legal));
    if (v.exp_legal) chk({p, "tag_rd_idx"}, 32'(tag_rd_idx_o), 32'(v.exp_idx));
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    if (!v.exp_legal) begin
      chk({p, "err_pulse"}, 32'(err_o), 32'd1);
      chk({p, "ready_after_err"}, 32'(req_ready_o), 32'd1);
      chk({p, "busy_after_err"}, 32'(busy_o), 32'd0);
      chk({p, "no_data_wr"}, 32'(data_wr_en_o), 32'd0);
      @(posedge clk_i); #1;
      chk({p, "err_cleared"}, 32'(err_o), 32'd0);
      chk({p, "no_mem_req"}, 32'(mem_req_valid_o), 32'd0);
      @(negedge clk_i);
      return;
    end
    chk({p, "lookup_busy"}, 32'(busy_o), 32'd1);
    chk({p, "lookup_ready"}, 32'(req_ready_o), 32'd0);
    chk({p, "lookup_err"}, 32'(err_o), 32'd0);
    chk({p, "data_wr_en"}, 32'(data_wr_en_o), 32'(v.exp_wr));
    if (v.exp_wr) begin
      chk({p, "data_wr_idx"}, 32'(data_wr_idx_o), 32'(v.exp_idx));
      chk({p, "data_wr_off"}, 32'(data_wr_off_o), 32'(v.exp_off));
      chk({p, "data_wr_be"}, 32'(data_wr_be_o), 32'(v.exp_be));
      chk({p, "data_wr_data"}, data_wr_data_o, v.exp_data);
    end
    @(posedge clk_i); #1;
    chk({p, "data_wr_done"}, 32'(data_wr_en_o), 32'd0);
    for (int c = 0; c <= stall; c++) begin
      chk({p, $sformatf("mem_valid_c%0d", c)}, 32'(mem_req_valid_o), 32'd1);
      chk({p, $sformatf("mem_addr_c%0d", c)}, mem_req_addr_o, v.exp_maddr);
      chk({p, $sformatf("mem_data_c%0d", c)}, mem_req_data_o, v.exp_data);
      chk({p, $sformatf("mem_be_c%0d", c)}, 32'(mem_req_be_o), 32'(v.exp_be));
      chk({p, $sformatf("ready_c%0d", c)}, 32'(req_ready_o), 32'd0);
      if (c == stall) mem_req_ready_i = 1'b1;
      else begin
        @(posedge clk_i); #1;
      end
    end
    @(posedge clk_i); #1;
    mem_req_ready_i = 1'b0;
    chk({p, "resp_mem_valid"}, 32'(mem_req_valid_o), 32'd0);
    chk({p, "resp_busy"}, 32'(busy_o), 32'd1);
    mem_resp_valid_i = 1'b1;
    mem_resp_err_i   = rerr;
    #1;
    chk({p, "resp_err"}, 32'(err_o), 32'(rerr));
    @(posedge clk_i); #1;
    mem_resp_valid_i = 1'b0;
    mem_resp_err_i   = 1'b0;
    chk({p, "done_ready"}, 32'(req_ready_o), 32'd1);
    chk({p, "done_busy"}, 32'(busy_o), 32'd0);
    chk({p, "done_err"}, 32'(err_o), 32'd0);
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          op      addr          data          tm vld lg wr idx    off   be    exp_data      exp_maddr
    vecs[0] = '{LSU_SW, 32'h80001004, 32'hDEADBEEF, 1, 1, 1, 1, 6'h00, 3'd1, 4'hF, 32'hDEADBEEF, 32'h80001004};
    vecs[1] = '{LSU_SB, 32'h80002003, 32'h000000AB, 0, 1, 1, 0, 6'h00, 3'd0, 4'h8, 32'hAB000000, 32'h80002000};
    vecs[2] = '{LSU_SH, 32'h80000001, 32'h00001234, 1, 1, 0, 0, 6'h00, 3'd0, 4'h0, 32'h00000000, 32'h00000000};
    vecs[3] = '{LSU_SH, 32'h80000042, 32'h0000BEEF, 1, 1, 1, 1, 6'h02, 3'd0, 4'hC, 32'hBEEF0000, 32'h80000040};
    vecs[4] = '{LSU_SB, 32'h800007E5, 32'h00000011, 1, 0, 1, 0, 6'h3F, 3'd1, 4'h2, 32'h00001100, 32'h800007E4};
    vecs[5] = '{LSU_SW, 32'h80000102, 32'h12345678, 1, 1, 0, 0, 6'h00, 3'd0, 4'h0, 32'h00000000, 32'h00000000};
    vecs[6] = '{LSU_SD, 32'h80000000, 32'h12345678, 1, 1, 0, 0, 6'h00, 3'd0, 4'h0, 32'h00000000, 32'h00000000};
    vecs[7] = '{LSU_SB, 32'h8000001E, 32'h000000C3, 1, 1, 1, 1, 6'h00, 3'd7, 4'h4, 32'h00C30000, 32'h8000001C};
    vecs[8] = '{LSU_SH, 32'h80000FFE, 32'h0000A55A, 1, 1, 1, 1, 6'h3F, 3'd7, 4'hC, 32'hA55A0000, 32'h80000FFC};

    rst_ni           = 1'b0;
    req_valid_i      = 1'b0;
    req_addr_i       = '0;
    req_data_i       = '0;
    req_op_i         = LSU_SB;
    tag_rd_tag_i     = '0;
    tag_rd_vld_i     = 1'b0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_err_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst ready", 32'(req_ready_o), 32'd1);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst err", 32'(err_o), 32'd0);
    chk("rst mem_valid", 32'(mem_req_valid_o), 32'd0);
    chk("rst tag_rd_en", 32'(tag_rd_en_o), 32'd0);
    chk("rst data_wr_en", 32'(data_wr_en_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 9; i++) run_store(i, vecs[i], 0, 1'b0);

    // Bus held off for 5 cycles: payload must stay put for 6 cycles.
    run_store(100, vecs[0], 5, 1'b0);
    // Bus error on the response, then a normal store right after.
    run_store(101, vecs[3], 0, 1'b1);
    run_store(102, vecs[1], 0, 1'b0);

    // Reset while the bus write is pending.
    tag_rd_tag_i = vecs[3].addr[31:11];
    tag_rd_vld_i = 1'b1;
    req_valid_i  = 1'b1;
    req_addr_i   = vecs[3].addr;
    req_data_i   = vecs[3].data;
    req_op_i     = vecs[3].op;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rstmid mem_valid_before", 32'(mem_req_valid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rstmid mem_valid_async", 32'(mem_req_valid_o), 32'd0);
    chk("rstmid busy_async", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rstmid ready_after", 32'(req_ready_o), 32'd1);
    chk("rstmid busy_after", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    run_store(103, vecs[8], 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
